// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO in front of an 8N1 serial transmitter, LSB first, CLK_DIV clk/bit.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit (8E1).
module uart_tx_buffer #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrreq,
  input  logic [7:0]            wrdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  txd,
  output logic                  busy
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] CountFull = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                 r_state, w_state_d;
  logic [7:0]             r_mem [Depth];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]    r_count;
  logic                   r_overflow;
  logic [7:0]             r_shift, w_shift_d;
  logic [2:0]             r_bit_idx, w_bit_idx_d;
  logic [BaudW-1:0]       r_baud_cnt, w_baud_cnt_d;
  logic                   r_txd, w_txd_d;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity, w_parity_d;
`endif

  logic                   w_full, w_empty, w_push, w_pop, w_baud_done;
  logic [7:0]             w_head;

  assign w_full      = (r_count == CountFull);
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_done = (r_baud_cnt == BaudMax);
  // A pop in the same cycle frees the slot, so a push at full is still accepted then.
  assign w_push      = wrreq & (~w_full | w_pop);

  // FIFO storage and bookkeeping
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wrdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (wrreq && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM state and registered line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
      r_txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_bit_idx  <= w_bit_idx_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_txd      <= w_txd_d;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_d;
`endif
    end
  end

  // w_txd_d is the line level for the state being entered, so txd lines up with r_state.
  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_bit_idx_d  = r_bit_idx;
    w_baud_cnt_d = r_baud_cnt;
    w_txd_d      = 1'b1;
    w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_d   = r_parity;
`endif
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_d    = StStart;
          w_shift_d    = w_head;
          w_baud_cnt_d = '0;
          w_txd_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_d   = ^w_head;
`endif
        end
      end
      StStart: begin
        w_txd_d = 1'b0;
        if (w_baud_done) begin
          w_state_d    = StData;
          w_bit_idx_d  = '0;
          w_baud_cnt_d = '0;
          w_txd_d      = r_shift[0];
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
      StData: begin
        w_txd_d = r_shift[0];
        if (w_baud_done) begin
          w_baud_cnt_d = '0;
          w_shift_d    = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
            w_txd_d   = r_parity;
`else
            w_state_d = StStop;
            w_txd_d   = 1'b1;
`endif
          end else begin
            w_bit_idx_d = r_bit_idx + 1'b1;
            w_txd_d     = r_shift[1];
          end
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        w_txd_d = r_parity;
        if (w_baud_done) begin
          w_state_d    = StStop;
          w_baud_cnt_d = '0;
          w_txd_d      = 1'b1;
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
`endif
      StStop: begin
        if (w_baud_done) begin
          w_state_d    = StIdle;
          w_baud_cnt_d = '0;
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_baud_cnt_d = '0;
      end
    endcase
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign txd      = r_txd;
  assign busy     = (r_state != StIdle);

endmodule
